// File: rtl/watchdog_pkg.sv
// Shared constants for the heartbeat watchdog: clock rate, default
// warning/timeout thresholds and the width of the elapsed-cycle counter.
`timescale 1ns/1ps
package watchdog_pkg;

  localparam int unsigned CLK_HZ                 = 125_000_000;
  localparam int unsigned COUNT_WIDTH            = 32;

  // Five seconds to timeout, four seconds to the early warning.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5 * CLK_HZ;
  localparam int unsigned DEFAULT_WARN_CYCLES    = 4 * CLK_HZ;

endpackage

// File: rtl/watchdog_timer_unit.sv
// Heartbeat watchdog. Counts cycles since the last kick from the supervising
// logic, raises a warning before the deadline and a sticky force_reset once
// the deadline passes. The counter saturates at the timeout, so force_reset
// stays up until a heartbeat, a disable or a reset clears everything.
`timescale 1ns/1ps
module watchdog_timer_unit
  import watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned WARN_CYCLES    = DEFAULT_WARN_CYCLES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   heartbeat,
  output logic                   force_reset,
  output logic                   warning,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] WARN_LIMIT    = COUNT_WIDTH'(WARN_CYCLES);

  // Reject threshold combinations that would make the warning meaningless
  // or the timeout unreachable.
  if (TIMEOUT_CYCLES < 2 || WARN_CYCLES < 1 || WARN_CYCLES >= TIMEOUT_CYCLES) begin : g_bad_params
    $error("watchdog_timer_unit: need 1 <= WARN_CYCLES < TIMEOUT_CYCLES and TIMEOUT_CYCLES >= 2");
  end

  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   at_limit;

  // Incremented count and saturation flag feeding the register update.
  always_comb begin
    count_inc = count + COUNT_WIDTH'(1);
    at_limit  = (count == TIMEOUT_LIMIT);
  end

  // Counter and flag registers: disable and heartbeat both clear, otherwise count up to the limit and hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count       <= '0;
      warning     <= 1'b0;
      force_reset <= 1'b0;
    end else if (!enable || heartbeat) begin
      count       <= '0;
      warning     <= 1'b0;
      force_reset <= 1'b0;
    end else if (!at_limit) begin
      count       <= count_inc;
      warning     <= (count_inc >= WARN_LIMIT);
      force_reset <= (count_inc == TIMEOUT_LIMIT);
    end
  end

`ifndef SYNTHESIS
  // Structural invariants relating the flags to the counter value.
  a_force_implies_warn : assert property (@(posedge clk) disable iff (!rstn) force_reset |-> warning);
  a_force_at_limit     : assert property (@(posedge clk) disable iff (!rstn) force_reset |-> (count == TIMEOUT_LIMIT));
  a_count_bounded      : assert property (@(posedge clk) disable iff (!rstn) count <= TIMEOUT_LIMIT);
  a_warn_matches_count : assert property (@(posedge clk) disable iff (!rstn) warning == (count >= WARN_LIMIT));
  a_disable_clears     : assert property (@(posedge clk) disable iff (!rstn)
                                          !enable |=> (count == '0 && !warning && !force_reset));
  c_timeout_then_clear : cover property (@(posedge clk) disable iff (!rstn) force_reset ##1 !force_reset);
`endif

endmodule

// File: tb/tb_watchdog_timer_unit.sv
// Scoreboard bench for the heartbeat watchdog with small thresholds.
// Each driven cycle pushes the expected outputs from an age-since-kick model;
// the entry is popped and compared once the DUT has taken that clock edge.
`timescale 1ns/1ps
module tb_watchdog_timer_unit;

  localparam int unsigned TMO = 16;
  localparam int unsigned WRN = 12;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        heartbeat;
  logic        force_reset;
  logic        warning;
  logic [31:0] count;

  typedef struct {
    int unsigned cnt;
    logic        warn;
    logic        frc;
  } exp_t;

  exp_t        expQ[$];
  int unsigned modelAge = 0;
  int          errors   = 0;
  int          checks   = 0;

  watchdog_timer_unit #(
    .TIMEOUT_CYCLES(TMO),
    .WARN_CYCLES   (WRN)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .heartbeat  (heartbeat),
    .force_reset(force_reset),
    .warning    (warning),
    .count      (count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL sim_timeout: got no finish, expected finish before 100us");
    $fatal(1, "[TB] simulation time limit expired");
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
  task automatic applyStimulus(input logic en, input logic hb, input string tag);
    exp_t e;
    @(negedge clk);
    enable    = en;
    heartbeat = hb;
    if (!rstn || !en || hb) modelAge = 0;
    else if (modelAge < TMO) modelAge++;
    e.cnt  = modelAge;
    e.warn = (modelAge >= WRN);
    e.frc  = (modelAge >= TMO);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput({tag, " count"},   count,               e.cnt);
    checkOutput({tag, " warning"}, {31'b0, warning},     {31'b0, e.warn});
    checkOutput({tag, " force"},   {31'b0, force_reset}, {31'b0, e.frc});
  endtask

  // Direct check that everything is cleared (used around asynchronous reset).
  task automatic checkCleared(input string tag);
    checkOutput({tag, " count"},   count,               32'd0);
    checkOutput({tag, " warning"}, {31'b0, warning},     32'd0);
    checkOutput({tag, " force"},   {31'b0, force_reset}, 32'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    enable    = 1'b0;
    heartbeat = 1'b0;
    #12;
    checkCleared("reset");

    // Reset held low overrides an enabled, kick-free cycle.
    applyStimulus(1'b1, 1'b0, "rst_hold");
    rstn = 1'b1;

    // Free run: warning at edge 12, force at edge 16, count saturates at 16.
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 1'b0, $sformatf("free e%0d", i));

    // Kick after timeout clears force_reset and counting resumes.
    applyStimulus(1'b1, 1'b1, "kick_after_to");
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, $sformatf("resume e%0d", i));

    // Heartbeat at edge 10 restarts the count; force arrives at edge 26.
    applyStimulus(1'b0, 1'b0, "disable");
    for (int i = 1; i <= 26; i++) applyStimulus(1'b1, (i == 10), $sformatf("kick10 e%0d", i));

    // After timeout, disable together with heartbeat plus a reset pulse; restart from 1.
    applyStimulus(1'b0, 1'b1, "dis_and_kick");
    rstn = 1'b0;
    #2;
    checkCleared("rst_pulse");
    rstn = 1'b1;
    modelAge = 0;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, $sformatf("reenable e%0d", i));

    // Heartbeat exactly on the edge that would reach the timeout.
    applyStimulus(1'b0, 1'b0, "clear");
    for (int i = 1; i <= 31; i++) applyStimulus(1'b1, (i == 16), $sformatf("kick16 e%0d", i));

    // Asynchronous reset mid-cycle at count 7 clears outputs before the next edge.
    applyStimulus(1'b0, 1'b0, "clear2");
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, $sformatf("pre_async e%0d", i));
    #2;
    rstn = 1'b0;
    #1;
    modelAge = 0;
    checkCleared("async_rst");
    applyStimulus(1'b1, 1'b0, "async_hold");
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, $sformatf("post_async e%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
